// File: rtl/timer_pkg.sv
// Shared types and constants for the elapsed-time controller.
// Optional feature macro: TIMER_PAUSE_EN (adds the PAUSE state).
package timer_pkg;

  localparam int TIME_W = 8;
  localparam logic [TIME_W-1:0] SEC_MAX = 8'd59;

`ifdef TIMER_PAUSE_EN
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    PAUSE = 2'd2,
    DONE  = 2'd3
  } timer_state_t;
`else
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd3
  } timer_state_t;
`endif

endpackage

// File: rtl/timer_controller_tick_gen.sv
// One-second prescaler: emits a single-cycle tick every TICK_DIV enabled clocks.
// Holds its phase while disabled so a resumed run keeps the partial second.
module tick_gen #(
  parameter int TICK_DIV = 50000000
) (
  input  logic clock,
  input  logic reset,
  input  logic clr,
  input  logic en,
  output logic tick
);

  localparam int CW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [CW-1:0] LAST = CW'(TICK_DIV - 1);

  logic [CW-1:0] cnt;

  assign tick = en && (cnt == LAST);

  // Phase counter: clear wins, otherwise advance and wrap while enabled.
  always_ff @(posedge clock or posedge reset) begin
    if (reset)      cnt <= '0;
    else if (clr)   cnt <= '0;
    else if (en)    cnt <= tick ? '0 : cnt + 1'b1;
  end

endmodule

// File: rtl/timer_controller.sv
// Elapsed-time controller: counts mm:ss upward from 00:00 to LIMIT_MIN:59.
// Count-down presentation is left to the display encoder via ModeSel.
// Optional feature macro: TIMER_PAUSE_EN (StartStop toggles RUN/PAUSE).
module timer_controller
  import timer_pkg::*;
#(
  parameter int TICK_DIV  = 50000000,
  parameter int LIMIT_MIN = 1
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              StartStop,
  input  logic              Clear,
  input  logic              ModeIn,
  output logic [TIME_W-1:0] LSBBinary,
  output logic [TIME_W-1:0] MSBBinary,
  output logic              ModeSel,
  output logic              disp_end,
  output logic              Running
);

  localparam logic [TIME_W-1:0] LIMIT_V = TIME_W'(LIMIT_MIN);

  timer_state_t      state;
  logic              tick;
  logic [TIME_W-1:0] sec_inc, min_inc;
  logic              at_term;

  // Prescaler is parked at zero while idle so every start begins a full second.
  tick_gen #(.TICK_DIV(TICK_DIV)) u_tick (
    .clock (clock),
    .reset (reset),
    .clr   (Clear || (state == IDLE)),
    .en    (state == RUN),
    .tick  (tick)
  );

  // Next mm:ss value and whether it lands on the terminal time.
  always_comb begin
    sec_inc = (LSBBinary == SEC_MAX) ? '0 : LSBBinary + 1'b1;
    min_inc = (LSBBinary == SEC_MAX) ? MSBBinary + 1'b1 : MSBBinary;
    at_term = (min_inc == LIMIT_V) && (sec_inc == SEC_MAX);
  end

  // Control FSM with registered outputs; Clear overrides every other event.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      LSBBinary <= '0;
      MSBBinary <= '0;
      ModeSel   <= 1'b0;
      disp_end  <= 1'b0;
      Running   <= 1'b0;
    end else if (Clear) begin
      state     <= IDLE;
      LSBBinary <= '0;
      MSBBinary <= '0;
      disp_end  <= 1'b0;
      Running   <= 1'b0;
    end else begin
      case (state)
        IDLE: if (StartStop) begin
          state   <= RUN;
          ModeSel <= ModeIn;
          Running <= 1'b1;
        end
        RUN: begin
          if (tick) begin
            LSBBinary <= sec_inc;
            MSBBinary <= min_inc;
          end
          if (tick && at_term) begin
            state    <= DONE;
            disp_end <= 1'b1;
            Running  <= 1'b0;
          end
`ifdef TIMER_PAUSE_EN
          else if (StartStop) begin
            state   <= PAUSE;
            Running <= 1'b0;
          end
`endif
        end
`ifdef TIMER_PAUSE_EN
        PAUSE: if (StartStop) begin
          state   <= RUN;
          Running <= 1'b1;
        end
`endif
        DONE: ;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_timer_controller.sv
// Randomized + directed bench for timer_controller (TICK_DIV=4, LIMIT_MIN=1).
module tb_timer_controller;

  localparam int DIV  = 4;
  localparam int LIM  = 1;
  localparam int TERM = LIM * 60 + 59;

  logic       clock = 0, reset = 1;
  logic       StartStop = 0, Clear = 0, ModeIn = 0;
  logic [7:0] LSBBinary, MSBBinary;
  logic       ModeSel, disp_end, Running;

  int total = 0, bad = 0;

  // Reference: elapsed time as a plain seconds count plus activity flags.
  int m_secs, m_phase;
  bit m_mode, m_active, m_hold, m_end;   // active=counting, hold=paused, end=terminal

  timer_controller #(.TICK_DIV(DIV), .LIMIT_MIN(LIM)) dut (
    .clock(clock), .reset(reset), .StartStop(StartStop), .Clear(Clear), .ModeIn(ModeIn),
    .LSBBinary(LSBBinary), .MSBBinary(MSBBinary), .ModeSel(ModeSel),
    .disp_end(disp_end), .Running(Running)
  );

  always #5 clock = ~clock;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%0d expected=%0d", nm, act, exp);
    end
  endtask

  function automatic bit pause_en();
`ifdef TIMER_PAUSE_EN
    return 1'b1;
`else
    return 1'b0;
`endif
  endfunction

  function automatic bit m_idle();
    return !m_active && !m_hold && !m_end;
  endfunction

  task automatic model_reset();
    m_secs = 0; m_phase = 0; m_mode = 0; m_active = 0; m_hold = 0; m_end = 0;
  endtask

  // Advance the reference by one clock edge given the sampled inputs.
  task automatic model_step(input bit ss, input bit clr, input bit mi);
    bit t;
    if (clr) begin
      m_secs = 0; m_phase = 0; m_active = 0; m_hold = 0; m_end = 0;
    end else if (m_active) begin
      t = (m_phase == DIV - 1);
      m_phase = (m_phase + 1) % DIV;
      if (t) m_secs++;
      if (t && m_secs == TERM) begin
        m_active = 0; m_end = 1;
      end else if (ss && pause_en()) begin
        m_active = 0; m_hold = 1;
      end
    end else if (m_hold) begin
      if (ss) begin m_hold = 0; m_active = 1; end
    end else if (!m_end) begin
      if (ss) begin m_active = 1; m_mode = mi; m_phase = 0; end
    end
  endtask

  task automatic compare();
    chk("sec", LSBBinary, m_secs % 60);
    chk("min", MSBBinary, m_secs / 60);
    chk("mode", ModeSel, m_mode);
    chk("end", disp_end, m_end);
    chk("run", Running, m_active);
  endtask

  // One clock: drive at negedge, step model, check after the posedge.
  task automatic cyc(input bit ss, input bit clr, input bit mi);
    @(negedge clock);
    StartStop = ss; Clear = clr; ModeIn = mi;
    model_step(ss, clr, mi);
    @(posedge clock);
    #1;
    compare();
  endtask

  task automatic idle_n(input int n);
    for (int i = 0; i < n; i++) cyc(0, 0, ModeIn);
  endtask

  // Run until the model's prescaler reaches ph while counting (bounded).
  task automatic to_phase(input int ph);
    int k;
    for (k = 0; k < 2 * DIV && !(m_active && m_phase == ph); k++) cyc(0, 0, ModeIn);
    chk("phase_sync", (m_active && m_phase == ph), 1);
  endtask

  int s0;

  initial begin
    model_reset();
    #1;
    chk("rst_lsb", LSBBinary, 0);
    chk("rst_run", Running, 0);
    chk("rst_end", disp_end, 0);
    @(posedge clock); #1;
    reset = 0;

    // First edge after release honours StartStop; mode latched from ModeIn.
    cyc(1, 0, 1);
    chk("modesel_load", ModeSel, 1);
    chk("running_start", Running, 1);
    cyc(0, 0, 0); cyc(0, 0, 1); cyc(0, 0, 0);
    chk("lsb_before_tick", LSBBinary, 0);
    cyc(0, 0, 0);
    chk("lsb_first_tick", LSBBinary, 1);
    chk("modesel_hold", ModeSel, 1);

    // Run to 00:07, then reset asynchronously between edges.
    idle_n(6 * DIV);
    chk("at_7", LSBBinary, 7);
    #2 reset = 1;
    #1;
    chk("arst_lsb", LSBBinary, 0);
    chk("arst_mode", ModeSel, 0);
    chk("arst_run", Running, 0);
    model_reset();
    @(posedge clock); #1;
    reset = 0;
    cyc(0, 0, 0);
    chk("idle_after_rst", Running, 0);

    // Full run to terminal time with wrap at 00:59 -> 01:00.
    cyc(1, 0, 0);
    idle_n(59 * DIV);
    chk("at_059", {MSBBinary, LSBBinary}, {8'd0, 8'd59});
    idle_n(DIV);
    chk("wrap_100", {MSBBinary, LSBBinary}, {8'd1, 8'd0});
    idle_n(59 * DIV - 1);
    chk("end_low_pre", disp_end, 0);
    idle_n(1);
    chk("end_high", disp_end, 1);
    chk("term_time", {MSBBinary, LSBBinary}, {8'd1, 8'd59});
    cyc(1, 0, 0);
    idle_n(2 * DIV);
    chk("done_frozen", {MSBBinary, LSBBinary, disp_end}, {8'd1, 8'd59, 1'b1});
    cyc(0, 1, 0);
    chk("clear_done", {MSBBinary, LSBBinary, disp_end}, {16'd0, 1'b0});

    // Clear + StartStop in IDLE stays idle.
    cyc(1, 1, 1);
    chk("clr_ss_idle", Running, 0);

    // Tick + StartStop in the same cycle.
    cyc(1, 0, 0);
    to_phase(DIV - 1);
    s0 = LSBBinary;
    cyc(1, 0, 0);
    chk("tick_ss_count", LSBBinary, s0 + 1);
    chk("tick_ss_run", Running, !pause_en());

    // Tick + Clear in the same cycle.
    if (!m_active) cyc(1, 0, 0);
    to_phase(DIV - 1);
    cyc(0, 1, 0);
    chk("tick_clr", {MSBBinary, LSBBinary}, 16'd0);

`ifdef TIMER_PAUSE_EN
    // Pause with prescaler at phase 2, hold, resume -> increment 2 clocks later.
    cyc(1, 0, 0);
    idle_n(DIV);
    to_phase(1);
    s0 = LSBBinary;
    cyc(1, 0, 0);
    idle_n(100);
    chk("pause_hold", LSBBinary, s0);
    cyc(1, 0, 0);
    cyc(0, 0, 0);
    chk("resume_1clk", LSBBinary, s0);
    cyc(0, 0, 0);
    chk("resume_2clk", LSBBinary, s0 + 1);
`else
    // StartStop in RUN ignored; counting continues.
    cyc(1, 0, 0);
    idle_n(DIV);
    s0 = LSBBinary;
    cyc(1, 0, 0);
    chk("ss_ignored_run", Running, 1);
    idle_n(2 * DIV);
    chk("ss_ignored_cnt", LSBBinary, s0 + 2);
`endif

    // Randomized traffic checked each cycle against the reference.
    cyc(0, 1, 0);
    for (int i = 0; i < 4000; i++)
      cyc($urandom_range(0, 24) == 0, $urandom_range(0, 399) == 0, 1'($urandom));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
